// File: rtl/press_emitter_pkg.sv
// Shared types and constants for the press emitter and its phase timer.
// The debounce window is the downstream debouncer settle time a press must outlast.
package press_emitter_pkg;

  localparam int unsigned COUNT_W          = 10;
  localparam int unsigned DEBOUNCE_SAMPLES = 8;
  localparam int unsigned DEBOUNCE_TICK    = 50001;
  localparam int unsigned DEBOUNCE_WINDOW  = DEBOUNCE_SAMPLES * DEBOUNCE_TICK;
  // Holds below this are unit-level configs that never drive the real debouncer
  localparam int unsigned SHORT_HOLD_MAX   = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/phase_timer.sv
// Times one press or release phase and shapes the line level, adding optional
// contact bounce at the start of the phase from a sub-counter (no divider).
module phase_timer #(
  parameter int unsigned HOLD_CYCLES   = 500000,
  parameter int unsigned BOUNCE_EDGES  = 0,
  parameter int unsigned BOUNCE_PERIOD = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_restart,
  input  logic i_level,
  output logic o_phase_end_c,
  output logic o_level
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned SUB_W = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
  localparam int unsigned IDX_W = (BOUNCE_EDGES > 0) ? $clog2(BOUNCE_EDGES + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BOUNCE_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(BOUNCE_EDGES);

  logic [CNT_W-1:0] r_cnt;
  logic [SUB_W-1:0] r_sub;
  logic [IDX_W-1:0] r_idx;
  logic             r_level;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [SUB_W-1:0] w_sub_nxt;
  logic [IDX_W-1:0] w_idx_nxt;

  // Next counter values; the sub-interval index saturates once bounce is over
  always_comb begin
    w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
    w_sub_nxt = r_sub;
    w_idx_nxt = r_idx;
    if (r_idx != IDX_END) begin
      if (r_sub == SUB_LAST) begin
        w_sub_nxt = '0;
        w_idx_nxt = r_idx + IDX_W'(1);
      end else begin
        w_sub_nxt = r_sub + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_sub   <= '0;
      r_idx   <= '0;
      r_level <= 1'b1;
    end else if (i_restart) begin
      r_cnt   <= '0;
      r_sub   <= '0;
      r_idx   <= '0;
      r_level <= i_level;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_sub   <= w_sub_nxt;
      r_idx   <= w_idx_nxt;
      r_level <= (w_idx_nxt != IDX_END) ? (i_level ^ w_idx_nxt[0]) : i_level;
    end
  end

  assign o_phase_end_c = (r_cnt == CNT_LAST);
  assign o_level       = r_level;

endmodule

// File: rtl/press_emitter.sv
// Emits a latched number of press/release cycles on an active-low button line,
// each phase long enough for a downstream debouncer to register one press.
module press_emitter
  import press_emitter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 500000,
  parameter int unsigned BOUNCE_EDGES  = 0,
  parameter int unsigned BOUNCE_PERIOD = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] count,
  output logic               pulse_out,
  output logic               busy,
  output logic               done
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [COUNT_W-1:0] r_remaining;
  logic [COUNT_W-1:0] w_remaining_nxt;
  logic               r_busy;
  logic               r_done;
  logic               w_done_nxt;
  logic               w_phase_end;
  logic               w_restart;
  logic               w_level;
  logic               w_line;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= w_done_nxt;
    end
  end

  // Next state; outputs are registered from next-state values so they track the state
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_done_nxt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            w_state_nxt     = PRESS;
            w_remaining_nxt = count;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      PRESS: begin
        if (w_phase_end) w_state_nxt = RELEASE;
      end
      RELEASE: begin
        if (w_phase_end) begin
          w_remaining_nxt = (r_remaining != '0) ? r_remaining - COUNT_W'(1) : '0;
          if (w_remaining_nxt == '0) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = PRESS;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Idle keeps the timer parked at released level; any state change opens a new phase
    w_restart = (r_state == IDLE) || (w_state_nxt != r_state);
    w_level   = (w_state_nxt != PRESS);
  end

  phase_timer #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .BOUNCE_EDGES (BOUNCE_EDGES),
    .BOUNCE_PERIOD(BOUNCE_PERIOD)
  ) u_phase_timer (
    .clock        (clock),
    .reset        (reset),
    .i_restart    (w_restart),
    .i_level      (w_level),
    .o_phase_end_c(w_phase_end),
    .o_level      (w_line)
  );

  // Bounce must settle inside a phase, and full-size holds must outlast the debouncer
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (BOUNCE_EDGES * BOUNCE_PERIOD < HOLD_CYCLES);
      assert ((HOLD_CYCLES > DEBOUNCE_WINDOW) || (HOLD_CYCLES < SHORT_HOLD_MAX));
    end
  end

  assign pulse_out = w_line;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_press_emitter.sv
// Two emitters (clean edges, and bounced edges) against a time-indexed
// behavioural model, plus directed scenarios with hand-computed expectations.
module tb_press_emitter;

  logic       clk;
  logic       rst;
  logic [1:0] start_v;
  logic [9:0] count_v [2];
  wire  [1:0] pulse_v;
  wire  [1:0] busy_v;
  wire  [1:0] done_v;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  int hold_p [2] = '{8, 16};
  int be_p   [2] = '{0, 3};
  int bp_p   [2] = '{1, 2};

  press_emitter #(.HOLD_CYCLES(8), .BOUNCE_EDGES(0), .BOUNCE_PERIOD(1)) dut_a (
    .clock(clk), .reset(rst), .start(start_v[0]), .count(count_v[0]),
    .pulse_out(pulse_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  press_emitter #(.HOLD_CYCLES(16), .BOUNCE_EDGES(3), .BOUNCE_PERIOD(2)) dut_b (
    .clock(clk), .reset(rst), .start(start_v[1]), .count(count_v[1]),
    .pulse_out(pulse_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Line level t cycles after acceptance: even phases pressed, odd released
  function automatic bit exp_level(input int t, input int h, input int be, input int bp);
    int  ph = t / h;
    int  c  = t % h;
    bit  l  = bit'(ph % 2);
    if (c < be * bp) return l ^ bit'((c / bp) % 2);
    return l;
  endfunction

  bit m_active [2];
  int m_t      [2];
  int m_total  [2];
  bit e_pulse  [2];
  bit e_busy   [2];
  bit e_done   [2];

  // Model: a job is a window of 2*N*HOLD cycles after acceptance, done right after it
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      automatic bit act_n  = m_active[d];
      automatic int t_n    = m_t[d];
      automatic int tot_n  = m_total[d];
      automatic bit done_n = 1'b0;
      if (rst) begin
        act_n = 1'b0;
        t_n   = 0;
      end else if (act_n) begin
        t_n++;
        if (t_n == tot_n) begin
          act_n  = 1'b0;
          done_n = 1'b1;
        end
      end else if (start_v[d]) begin
        if (count_v[d] != 10'd0) begin
          act_n = 1'b1;
          t_n   = 0;
          tot_n = 2 * int'(count_v[d]) * hold_p[d];
        end else begin
          done_n = 1'b1;
        end
      end
      m_active[d] <= act_n;
      m_t[d]      <= t_n;
      m_total[d]  <= tot_n;
      e_done[d]   <= done_n;
      e_busy[d]   <= act_n;
      e_pulse[d]  <= act_n ? exp_level(t_n, hold_p[d], be_p[d], bp_p[d]) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("model_pulse%0d", d), 32'(pulse_v[d]), 32'(e_pulse[d]));
        check($sformatf("model_busy%0d", d),  32'(busy_v[d]),  32'(e_busy[d]));
        check($sformatf("model_done%0d", d),  32'(done_v[d]),  32'(e_done[d]));
      end
    end
  end

  // Advance n cycles on DUT d, tallying busy cycles, falling edges and done strobes
  task automatic run(input int d, input int n, output int busy_n, output int falls, output int dones);
    logic prev;
    prev   = pulse_v[d];
    busy_n = 0;
    falls  = 0;
    dones  = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start_v = '0;
      if (busy_v[d] === 1'b1) busy_n++;
      if (prev === 1'b1 && pulse_v[d] === 1'b0) falls++;
      if (done_v[d] === 1'b1) dones++;
      prev = pulse_v[d];
    end
  endtask

  initial begin
    int         b, f, dn, b2, f2, dn2;
    bit         found;
    logic [31:0] got_b;
    logic [31:0] exp_b;

    rst        = 1'b1;
    start_v    = '0;
    count_v[0] = '0;
    count_v[1] = '0;
    repeat (3) @(negedge clk);
    check("rst_pulse_a", 32'(pulse_v[0]), 32'd1);
    check("rst_busy_a",  32'(busy_v[0]),  32'd0);
    check("rst_done_b",  32'(done_v[1]),  32'd0);
    chk_en = 1'b1;
    rst    = 1'b0;
    @(negedge clk);

    // Clean three-press job
    count_v[0] = 10'd3;
    start_v[0] = 1'b1;
    run(0, 60, b, f, dn);
    check("n3_busy_cycles", 32'(b),  32'd48);
    check("n3_falls",       32'(f),  32'd3);
    check("n3_dones",       32'(dn), 32'd1);

    // Zero-count request
    count_v[0] = 10'd0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v = '0;
    check("n0_done",  32'(done_v[0]),  32'd1);
    check("n0_busy",  32'(busy_v[0]),  32'd0);
    check("n0_pulse", 32'(pulse_v[0]), 32'd1);
    run(0, 5, b, f, dn);
    check("n0_after_busy", 32'(b),  32'd0);
    check("n0_after_done", 32'(dn), 32'd0);

    // Bounced single press: literal waveform, LSB is the first cycle
    exp_b      = 32'hFFF3_000C;
    count_v[1] = 10'd1;
    start_v[1] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      start_v  = '0;
      got_b[i] = pulse_v[1];
    end
    check("bounce_waveform", got_b, exp_b);
    run(1, 5, b, f, dn);
    check("bounce_done", 32'(dn), 32'd1);

    // Restart and count change mid-job are ignored
    count_v[0] = 10'd5;
    start_v[0] = 1'b1;
    run(0, 20, b, f, dn);
    count_v[0] = 10'd1;
    start_v[0] = 1'b1;
    run(0, 100, b2, f2, dn2);
    check("ignore_falls", 32'(f + f2),   32'd5);
    check("ignore_dones", 32'(dn + dn2), 32'd1);
    check("ignore_busy",  32'(b + b2),   32'd80);

    // Start accepted in the done cycle
    count_v[0] = 10'd1;
    start_v[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      start_v = '0;
      if (done_v[0] === 1'b1) found = 1'b1;
    end
    check("b2b_done_seen", 32'(found), 32'd1);
    start_v[0] = 1'b1;
    run(0, 30, b, f, dn);
    check("b2b_busy",  32'(b),  32'd16);
    check("b2b_falls", 32'(f),  32'd1);
    check("b2b_dones", 32'(dn), 32'd1);

    // Reset during the second press aborts without done
    count_v[0] = 10'd4;
    start_v[0] = 1'b1;
    run(0, 19, b, f, dn);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_pulse", 32'(pulse_v[0]), 32'd1);
    check("abort_busy",  32'(busy_v[0]),  32'd0);
    check("abort_done",  32'(done_v[0]),  32'd0);
    run(0, 20, b, f, dn);
    check("abort_no_done", 32'(dn), 32'd0);
    count_v[0] = 10'd2;
    start_v[0] = 1'b1;
    run(0, 40, b, f, dn);
    check("after_abort_busy",  32'(b),  32'd32);
    check("after_abort_falls", 32'(f),  32'd2);
    check("after_abort_dones", 32'(dn), 32'd1);

    // Random starts, count changes and occasional resets on both emitters
    repeat (4000) begin
      @(negedge clk);
      start_v = '0;
      rst     = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 9) == 0) count_v[d] = 10'($urandom_range(0, 5));
        if ($urandom_range(0, 15) == 0) start_v[d] = 1'b1;
      end
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
    end
    @(negedge clk);
    start_v = '0;
    rst     = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/press_emitter.md
# press_emitter

Generates a programmable number of button-press waveforms on a single active-low line, the driving end of the debounce-and-count path. On `start` it latches a 10-bit press count and emits that many press/release cycles with configurable hold times and optional contact bounce. Each cycle is sized so that a downstream debouncer registers exactly one press. Used as an on-chip self-test source in place of a physical push button, and as a bench stimulus for the counting logic.

## Interface
- `HOLD_CYCLES`, 500000: clock cycles per press phase and per release phase. Must exceed the downstream debounce settle time (8 samples × 50001 cycles).
- `BOUNCE_EDGES`, 0: number of bounce sub-intervals at the start of each phase. 0 means clean edges.
- `BOUNCE_PERIOD`, 1000: cycles per bounce sub-interval. `BOUNCE_EDGES*BOUNCE_PERIOD < HOLD_CYCLES` is required.
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: request. Sampled only in IDLE.
- `count`, in, 10: number of presses. Latched when `start` is accepted.
- `pulse_out`, out, 1: button-style line. Idle/released = 1, pressed = 0.
- `busy`, out, 1: high from the cycle after acceptance until completion.
- `done`, out, 1: single-cycle completion strobe.

## Operation
- States: IDLE, PRESS, RELEASE.
- IDLE:
  - `pulse_out`=1, `busy`=0.
  - `start`=1 with `count`>0: latch `remaining`=`count`, clear the phase counter, go to PRESS.
  - `start`=1 with `count`=0: stay in IDLE and pulse `done` the next cycle; `pulse_out` never leaves 1.
- PRESS:
  - Target level L=0. Phase counter `c` runs 0..HOLD_CYCLES-1.
  - At `c`=HOLD_CYCLES-1, go to RELEASE and clear `c`.
- RELEASE:
  - Target level L=1. Same counting as PRESS.
  - At the end of the phase, decrement `remaining`.
  - If the result is 0, go to IDLE and assert `done` for one cycle; otherwise go to PRESS.
- Bounce:
  - While `c < BOUNCE_EDGES*BOUNCE_PERIOD`, `pulse_out` = L XOR (sub-interval index odd). The sub-interval index is `c`/BOUNCE_PERIOD, held as a separate sub-counter with no divider.
  - Otherwise `pulse_out` = L.
  - With BOUNCE_EDGES=0, `pulse_out` = L for the whole phase.
- `start` while not in IDLE is ignored. `count` changes after latching have no effect.
- Reset:
  - Values: state=IDLE, `pulse_out`=1, `busy`=0, `done`=0, counters=0.
  - Reset mid-operation aborts without `done`. `pulse_out` returns to 1 at the reset edge.
- `done` and `start` in the same cycle: `done` is from the previous job and `start` is accepted normally, because the state is already IDLE.
- Arithmetic and widths:
  - Phase counter width = $clog2(HOLD_CYCLES).
  - `remaining` is 10 bits, decrements only, and never wraps.
  - Maximum count 1023 gives 2046 phases.

## Timing
- All outputs are registered.
- `start` accepted at edge k: `busy`=1 and `pulse_out` = first PRESS level from edge k+1.
- Each phase lasts exactly HOLD_CYCLES cycles.
- Job with N>0: `busy` high for exactly 2·N·HOLD_CYCLES cycles. `done` is high in the first cycle after `busy` falls, coincident with IDLE.
- `count`=0: `done` at edge k+1, `busy` stays 0.
- Earliest next `start` is accepted in the `done` cycle.

## Structure
- Shared package `press_emitter_pkg` holds:
  - the state enum (IDLE, PRESS, RELEASE);
  - the `COUNT_W`=10 localparam;
  - the debounce-window constant used for the HOLD_CYCLES legality assertion.
- Sub-module `phase_timer` (HOLD_CYCLES, BOUNCE_EDGES, BOUNCE_PERIOD):
  - Inputs: `clock`, `reset`, `restart`, target level.
  - Outputs: `phase_end` strobe and the bounced level.
  - Owns the phase counter and the bounce sub-counter.
- The top level owns the FSM, `remaining`, `busy` and `done`.

## Test plan
- HOLD_CYCLES=8, BOUNCE_EDGES=0, `start` with `count`=3 -> `pulse_out` pattern (0×8, 1×8) repeated 3 times; `busy` high for 48 cycles; one `done` pulse; 3 falling edges.
- `count`=0 -> `done` the cycle after `start`; `busy` never high; `pulse_out` stays 1.
- HOLD_CYCLES=16, BOUNCE_EDGES=3, BOUNCE_PERIOD=2, `count`=1:
  - PRESS phase reads 0,0,1,1,0,0 then 0×10.
  - RELEASE phase reads 1,1,0,0,1,1 then 1×10.
- `count`=5 accepted, `count` changed to 1 and `start` re-pulsed mid-job -> exactly 5 presses, one `done`.
- `reset` asserted during the second PRESS of `count`=4 -> next cycle `pulse_out`=1, `busy`=0, no `done`; a new `start` with `count`=2 then runs cleanly.
- Loopback at real parameters into the debounced LED counter, `count`=7 -> LEDs read 7 after `done` plus debounce settle.
